// File: rtl/window3_avg_filter.sv
// Streaming 3x3 smoothing filter (box mean or 1-2-1 Gaussian) for raster-order pixels.
// Two line buffers build the window; fixed three-cycle latency from accept to output.
module window3_avg_filter #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             sof,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_sof,
    output logic             out_eol
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int SUM_W = PIX_W + 4;

    logic             frame_active;
    logic             frame_mode;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic             accept;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             cur_mode;
    logic             last_col;
    logic             last_row;
    logic             win_ok;

    // An accepted sof pins the pixel to (0,0) and restarts the frame.
    assign accept   = in_valid && (frame_active || sof);
    assign cur_col  = sof ? '0 : col;
    assign cur_row  = sof ? '0 : row;
    assign cur_mode = sof ? mode : frame_mode;
    assign last_col = (cur_col == COL_W'(IMG_W - 1));
    assign last_row = (cur_row == ROW_W'(IMG_H - 1));
    assign win_ok   = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_active <= 1'b0;
            frame_mode   <= 1'b0;
            col          <= '0;
            row          <= '0;
        end else if (accept) begin
            frame_active <= !(last_row && last_col);
            if (sof) frame_mode <= mode;
            col <= last_col ? '0 : cur_col + 1'b1;
            if (last_col) row <= last_row ? '0 : cur_row + 1'b1;
            else          row <= cur_row;
        end
    end

    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];

    // NOTE: the line buffers are flops, cleared on reset like any other state; RAM-style storage would skip the reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
        end else if (accept) begin
            lb1[0] <= in_pixel;
            lb2[0] <= lb1[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                lb1[i] <= lb1[i-1];
                lb2[i] <= lb2[i-1];
            end
        end
    end

    // Stage 0 captures the new column (rows r-2, r-1, r); stage 1 shifts it into the window.
    logic [PIX_W-1:0] tap [3];
    logic [PIX_W-1:0] win [3][3];
    logic             s0_acc, s0_valid, s0_sof, s0_eol, s0_mode;
    logic             s1_valid, s1_sof, s1_eol, s1_mode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_acc   <= 1'b0;
            s0_valid <= 1'b0;
            s0_sof   <= 1'b0;
            s0_eol   <= 1'b0;
            s0_mode  <= 1'b0;
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_mode  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                tap[i] <= '0;
                for (int j = 0; j < 3; j++) win[i][j] <= '0;
            end
        end else begin
            s0_acc   <= accept;
            s0_valid <= accept && win_ok;
            s0_sof   <= (cur_row == ROW_W'(2)) && (cur_col == COL_W'(2));
            s0_eol   <= last_col;
            s0_mode  <= cur_mode;
            if (accept) begin
                tap[0] <= lb2[IMG_W-1];
                tap[1] <= lb1[IMG_W-1];
                tap[2] <= in_pixel;
            end
            if (s0_acc) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                    win[i][2] <= tap[i];
                end
            end
            s1_valid <= s0_valid;
            s1_sof   <= s0_valid && s0_sof;
            s1_eol   <= s0_valid && s0_eol;
            s1_mode  <= s0_mode;
        end
    end

    logic [SUM_W-1:0] box_sum;
    logic [SUM_W-1:0] gauss_sum;

    // NOTE: both sums start from a default so the combinational block can never infer a latch.
    always_comb begin
        box_sum   = '0;
        gauss_sum = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                box_sum   = box_sum + SUM_W'(win[i][j]);
                gauss_sum = gauss_sum + (SUM_W'(win[i][j]) << (int'(i == 1) + int'(j == 1)));
            end
        end
    end

    logic [SUM_W-1:0] sum_q;
    logic             s2_valid, s2_sof, s2_eol, s2_mode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q     <= '0;
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_eol    <= 1'b0;
            s2_mode   <= 1'b0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            sum_q    <= s1_mode ? gauss_sum : box_sum;
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eol   <= s1_eol;
            s2_mode  <= s1_mode;

            out_valid <= s2_valid;
            out_sof   <= s2_valid && s2_sof;
            out_eol   <= s2_valid && s2_eol;
            // Divide by a constant 9 is exact; both quotients are bounded by 2^PIX_W-1.
            if (s2_valid)
                out_pixel <= s2_mode ? PIX_W'(sum_q >> 4) : PIX_W'(sum_q / SUM_W'(9));
        end
    end
endmodule

// File: tb/tb_window3_avg_filter.sv
// Scoreboard bench for window3_avg_filter: a 4x4 and a 5x5 instance, expected outputs
// queued (value, flags, arrival cycle) when stimulus is driven and checked at negedge.
module tb_window3_avg_filter;
    typedef struct {
        logic [7:0] pix;
        logic       s;
        logic       e;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       md [2];
    logic       sf [2];
    logic       iv [2];
    logic [7:0] ip [2];
    logic       ov [2];
    logic [7:0] op [2];
    logic       os [2];
    logic       oe [2];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   img [5][5];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    window3_avg_filter #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .reset(reset), .mode(md[0]), .sof(sf[0]), .in_valid(iv[0]), .in_pixel(ip[0]),
        .out_valid(ov[0]), .out_pixel(op[0]), .out_sof(os[0]), .out_eol(oe[0])
    );

    window3_avg_filter #(.PIX_W(8), .IMG_W(5), .IMG_H(5)) dut5 (
        .clk(clk), .reset(reset), .mode(md[1]), .sof(sf[1]), .in_valid(iv[1]), .in_pixel(ip[1]),
        .out_valid(ov[1]), .out_pixel(op[1]), .out_sof(os[1]), .out_eol(oe[1])
    );

    // Scoreboard side: every output must match the head of its queue, including arrival cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ov[d] === 1'b1) begin
                exp_t e;
                bit   have;
                have = 1'b0;
                if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                total++;
                if (!have) begin
                    bad++;
                    $display("FAIL unexpected_out dut%0d cyc=%0d: got pix=%0d sof=%0b eol=%0b, required no output",
                             d, cyc, op[d], os[d], oe[d]);
                end else if (op[d] !== e.pix || os[d] !== e.s || oe[d] !== e.e || cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL out dut%0d: got pix=%0d sof=%0b eol=%0b cyc=%0d, required pix=%0d sof=%0b eol=%0b cyc=%0d",
                             d, op[d], os[d], oe[d], cyc, e.pix, e.s, e.e, e.cyc);
                end
            end else begin
                total++;
                if (ov[d] !== 1'b0 || os[d] !== 1'b0 || oe[d] !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_flags dut%0d cyc=%0d: got valid=%0b sof=%0b eol=%0b, required 0 0 0",
                             d, cyc, ov[d], os[d], oe[d]);
                end
            end
        end
    end

    function automatic logic [7:0] model(int r, int c, bit m);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += m ? img[r-2+i][c-2+j] * ((i == 1 ? 2 : 1) * (j == 1 ? 2 : 1))
                       : img[r-2+i][c-2+j];
        return m ? 8'(s / 16) : 8'(s / 9);
    endfunction

    task automatic idle(int d, int n);
        iv[d] = 1'b0;
        sf[d] = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(int d, exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Sends one frame of img; optional random gaps and a mode-pin flip after the first two rows.
    task automatic send_frame(int d, int n, bit m, bit gaps, bit flip);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                if (gaps) idle(d, $urandom_range(0, 3));
                md[d] = (flip && r >= 1) ? ~m : m;
                sf[d] = (r == 0 && c == 0);
                iv[d] = 1'b1;
                ip[d] = 8'(img[r][c]);
                @(posedge clk); #1;
                iv[d] = 1'b0;
                sf[d] = 1'b0;
                if (r >= 2 && c >= 2)
                    push(d, '{pix: model(r, c, m), s: (r == 2 && c == 2), e: (c == n - 1), cyc: cyc + 3});
            end
        end
    endtask

    // Pixels with no expected outputs: a partial frame (with sof) or stray pixels (without).
    task automatic send_raw(int d, int count, int value, bit with_sof);
        for (int k = 0; k < count; k++) begin
            sf[d] = with_sof && (k == 0);
            iv[d] = 1'b1;
            ip[d] = 8'(value);
            @(posedge clk); #1;
        end
        iv[d] = 1'b0;
        sf[d] = 1'b0;
    endtask

    task automatic fill(int v);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) img[r][c] = v;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) @(posedge clk);
        idle(0, 6);
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL drain_%s: got %0d outputs still missing, required 0", name, q0.size() + q1.size());
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic check_quiet(string name);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({ov[d], op[d], os[d], oe[d]} !== 11'd0) begin
                bad++;
                $display("FAIL %s dut%0d: got valid=%0b pix=%0d sof=%0b eol=%0b, required all 0",
                         name, d, ov[d], op[d], os[d], oe[d]);
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            md[d] = 1'b0; sf[d] = 1'b0; iv[d] = 1'b0; ip[d] = 8'd0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_outputs");
        reset = 1'b1;
        idle(0, 2);
    endtask

    task automatic test_flat();
        fill(100);
        send_frame(0, 4, 1'b0, 1'b0, 1'b0);
        drain("flat");
    endtask

    task automatic test_ramp();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) img[r][c] = 16 * r + c;
        send_frame(0, 4, 1'b0, 1'b0, 1'b0);
        drain("ramp");
    endtask

    task automatic test_gauss_impulse();
        fill(0);
        img[2][2] = 255;
        send_frame(1, 5, 1'b1, 1'b0, 1'b0);
        drain("gauss");
    endtask

    task automatic test_gaps_mode();
        fill(255);
        send_frame(0, 4, 1'b0, 1'b1, 1'b1);
        drain("gaps_mode");
        md[0] = 1'b0;
    endtask

    task automatic test_reset_midframe();
        send_raw(0, 12, 50, 1'b1);
        reset = 1'b0;
        idle(0, 3);
        check_quiet("midframe_reset_outputs");
        reset = 1'b1;
        idle(0, 6);
        send_raw(0, 16, 50, 1'b0);
        fill(50);
        send_frame(0, 4, 1'b0, 1'b0, 1'b0);
        drain("after_reset");
        send_raw(0, 16, 50, 1'b0);
        drain("stray_pixels");
    endtask

    task automatic test_back_to_back();
        send_raw(0, 6, 9, 1'b1);
        fill(7);
        send_frame(0, 4, 1'b0, 1'b0, 1'b0);
        drain("restart");
    endtask

    initial begin
        test_reset();
        test_flat();
        test_ramp();
        test_gauss_impulse();
        test_gaps_mode();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
